if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC, drives the instruction-memory address, and produces the IF/ID pipeline register.
- Sits directly upstream of the load-use hazard unit.
- Consumes that unit's PC_Write and IFID_Write, plus redirects from branch/jump resolution in ID.
- Feeds IFID_Instr to the hazard unit and decode.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000000, encoding inserted as a bubble (sll $0,$0,0).

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
PC_Write  input  1  0 = hold PC (load-use stall)
IFID_Write  input  1  0 = hold IF/ID contents
Branch_Taken  input  1  taken branch resolved this cycle
Branch_Target  input  32  branch destination
Jump  input  1  jump resolved this cycle
Jump_Target  input  32  jump destination
imem_addr  output  32  fetch address (combinational = PC)
imem_req  output  1  fetch request, high in FETCH and MISS
imem_rdata  input  32  instruction word
imem_ready  input  1  imem_rdata valid for imem_addr this cycle
PC_out  output  32  current PC
IFID_PC4  output  32  PC+4 of the instruction held in IF/ID
IFID_Instr  output  32  instruction held in IF/ID
IFID_Valid  output  1  1 = IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at posedge):
  - PC=RESET_PC, state=BOOT.
  - IFID_Instr=NOP_INSTR, IFID_PC4=0, IFID_Valid=0.
  - rst overrides every other input, including mid-MISS.
- States:
  - BOOT: one cycle, imem_req=0, PC held. Next state FETCH.
  - FETCH: imem_req=1. imem_ready=0 -> MISS, else stay.
  - MISS: imem_req=1, PC held. imem_ready=1 -> FETCH, else stay.
- Redirect = Jump | Branch_Taken. Target = Jump ? Jump_Target : Branch_Target (Jump wins). Target bits[1:0] forced to 0.
- Fetch complete (fc) = state in {FETCH, MISS} & imem_ready & PC_Write & !redirect.
- PC next-state priority: rst > redirect (PC=target, state=FETCH, any in-flight fetch discarded) > fc (PC=PC+4) > hold.
- PC+4 wraps modulo 2^32; 32'hFFFFFFFC+4 = 0.
- IF/ID next-state priority: rst > redirect (bubble) > IFID_Write=0 (hold all three fields) > fc (Instr=imem_rdata, PC4=PC+4, Valid=1) > bubble.
  - Bubble = Instr NOP_INSTR, PC4 0, Valid 0.
- Redirect overrides stall: with redirect=1 and PC_Write=0, PC still takes target and IF/ID is flushed.
- PC_Write=0 with IFID_Write=1: IF/ID takes a bubble and the instruction is not duplicated.
- Latency: an instruction at PC appears in IF/ID on the posedge where imem_ready=1 with no stall or redirect. Single cycle for zero-wait memory.
- imem_addr and PC_out are combinational from the PC register. No output is combinational from imem_rdata.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds two outputs, each reset to 0 by rst, 32-bit, saturating at 32'hFFFFFFFF:
  - perf_stall_cycles: +1 each cycle PC_Write=0 & !redirect & !rst.
  - perf_flushes: +1 each cycle redirect=1 & !rst.
- Undefined: ports and counters absent. All other behaviour is identical.

Test Plan:
- Reset, then imem_ready=1 constant with imem_rdata=PC-derived words -> cycle after reset: BOOT, IFID_Valid=0. Then PC 0,4,8; IFID_PC4 4,8,12 in consecutive cycles.
- PC_Write=0, IFID_Write=0 for 1 cycle while PC=8 -> PC stays 8, IF/ID unchanged, next cycle fetches 8 -> IFID_PC4=12.
- Branch_Taken=1, Branch_Target=32'h40 while PC_Write=0 -> next PC=40, IFID_Valid=0, IFID_Instr=NOP_INSTR. Jump=1 and Branch_Taken=1 together -> Jump_Target used.
- imem_ready=0 for 3 cycles at PC=C -> state MISS, PC held at C, 3 bubbles. Redirect during MISS -> PC=target, old data never enters IF/ID.
- PC=32'hFFFFFFFC, fetch completes -> PC=0, IFID_PC4=0, IFID_Valid=1. Assert rst mid-MISS -> PC=RESET_PC, IFID_Valid=0 next cycle.
- With IF_PERF_CNT_EN: 5 stall cycles and 2 redirects -> perf_stall_cycles=5, perf_flushes=2. Preload near saturation -> holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage.
//
// Owns the PC, drives the instruction-memory address and produces the IF/ID
// pipeline register consumed by the load-use hazard unit and decode.
//
// Ports
//   clk, rst           : clock (posedge) and synchronous active-high reset
//   PC_Write           : 0 holds the PC (load-use stall)
//   IFID_Write         : 0 holds the IF/ID register
//   Branch_Taken/Target: branch redirect resolved in ID
//   Jump/Jump_Target   : jump redirect resolved in ID (wins over branch)
//   imem_addr/imem_req : fetch address (= PC) and request
//   imem_rdata/ready   : instruction word, valid for imem_addr when ready=1
//   PC_out             : current PC
//   IFID_PC4/Instr/Valid : IF/ID pipeline register
//
// Optional feature (macro IF_PERF_CNT_EN):
//   perf_stall_cycles  : saturating count of stalled, non-redirect cycles
//   perf_flushes       : saturating count of redirect cycles
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_Write,
    input  logic        IFID_Write,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC_out,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_Instr,
    output logic        IFID_Valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_MISS  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc4;
    logic        w_fc;

    assign w_redirect = Jump | Branch_Taken;
    // Jump wins; targets are word-aligned regardless of what ID hands us.
    assign w_target   = (Jump ? Jump_Target : Branch_Target) & 32'hFFFF_FFFC;
    assign w_pc4      = r_pc + 32'd4;
    // A fetch only completes when the word is here, the PC may advance and
    // nothing upstream is throwing this fetch away.
    assign w_fc       = (r_state != S_BOOT) & imem_ready & PC_Write & ~w_redirect;

    // FSM + PC. imem_req is registered alongside the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_req   <= 1'b0;
            r_pc    <= RESET_PC;
        end else if (w_redirect) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_pc    <= w_target;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (!imem_ready) r_state <= S_MISS;
                    r_req <= 1'b1;
                end
                S_MISS: begin
                    if (imem_ready) r_state <= S_FETCH;
                    r_req <= 1'b1;
                end
                default: begin
                    r_state <= S_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
            if (w_fc) r_pc <= w_pc4;
        end
    end

    // IF/ID register. A stalled PC with IFID_Write=1 inserts a bubble so the
    // held instruction is not issued twice.
    always_ff @(posedge clk) begin
        if (rst || w_redirect) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (!IFID_Write) begin
            r_ifid_instr <= r_ifid_instr;
            r_ifid_pc4   <= r_ifid_pc4;
            r_ifid_valid <= r_ifid_valid;
        end else if (w_fc) begin
            r_ifid_instr <= imem_rdata;
            r_ifid_pc4   <= w_pc4;
            r_ifid_valid <= 1'b1;
        end else begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end
    end

    assign imem_addr  = r_pc;
    assign PC_out     = r_pc;
    assign imem_req   = r_req;
    assign IFID_PC4   = r_ifid_pc4;
    assign IFID_Instr = r_ifid_instr;
    assign IFID_Valid = r_ifid_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (!PC_Write && !w_redirect && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_redirect && r_perf_flush != 32'hFFFF_FFFF)
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flushes      = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        t_rst, t_pcw, t_ifw, t_br, t_jp, t_rdy;
    logic [31:0] t_bt, t_jt, t_junk;
    logic [31:0] imem_addr, imem_rdata, PC_out, IFID_PC4, IFID_Instr;
    logic        imem_req, IFID_Valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flushes;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: PC, "first cycle after reset" flag, IF/ID contents.
    logic [31:0] m_pc, m_pc4, m_instr, m_stall, m_flush;
    logic        m_boot, m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC3A5_0F1E;
    endfunction

    // Memory: correct word when ready, garbage otherwise.
    assign imem_rdata = t_rdy ? word(imem_addr) : t_junk;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(t_rst), .PC_Write(t_pcw), .IFID_Write(t_ifw),
        .Branch_Taken(t_br), .Branch_Target(t_bt), .Jump(t_jp), .Jump_Target(t_jt),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
        .imem_ready(t_rdy), .PC_out(PC_out), .IFID_PC4(IFID_PC4),
        .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid)
`ifdef IF_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        logic        redir, fc;
        logic [31:0] tgt;
        if (t_rst) begin
            m_pc = RESET_PC; m_boot = 1'b1;
            m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
            m_stall = 32'd0; m_flush = 32'd0;
            return;
        end
        redir = t_jp | t_br;
        tgt   = (t_jp ? t_jt : t_bt) & ~32'd3;
        fc    = !m_boot && t_rdy && t_pcw && !redir;
        if (redir) begin
            m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (t_ifw) begin
            if (fc) begin m_instr = word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; end
            else begin m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0; end
        end
        if (!t_pcw && !redir && m_stall != '1) m_stall++;
        if (redir && m_flush != '1) m_flush++;
        if (redir) m_pc = tgt;
        else if (fc) m_pc = m_pc + 32'd4;
        m_boot = 1'b0;
    endtask

    // Present inputs, clock once, update the model, settle 1 time unit.
    task automatic tick();
        t_junk = $urandom;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        t_rst = 0; t_pcw = 1; t_ifw = 1; t_br = 0; t_jp = 0; t_rdy = 1;
        t_bt = 32'hDEAD_BEE0; t_jt = 32'hBAAD_F00C;
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_out", PC_out, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("imem_req", {31'd0, imem_req}, {31'd0, !m_boot});
            chk("ifid_instr", IFID_Instr, m_instr);
            chk("ifid_pc4", IFID_PC4, m_pc4);
            chk("ifid_valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
            chk("perf_stall", perf_stall_cycles, m_stall);
            chk("perf_flush", perf_flushes, m_flush);
`endif
        end
    end

    initial begin
        idle(); t_junk = 0;
        t_rst = 1; tick(); tick();
        chk_en = 1'b1;
        // Reset state.
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("rst_instr", IFID_Instr, NOP_INSTR);

        // Zero-wait stream: BOOT, then PC 0,4,8.
        idle(); tick();
        chk("boot_pc", PC_out, 32'h0);
        chk("boot_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("s1_pc", PC_out, 32'h4);
        chk("s1_pc4", IFID_PC4, 32'h4);
        chk("s1_instr", IFID_Instr, 32'hC3A5_0F1E);
        tick();
        chk("s2_pc", PC_out, 32'h8);
        chk("s2_pc4", IFID_PC4, 32'h8);

        // Full stall at PC=8.
        t_pcw = 0; t_ifw = 0; tick();
        chk("stall_pc", PC_out, 32'h8);
        chk("stall_pc4", IFID_PC4, 32'h8);
        idle(); tick();
        chk("post_stall_pc4", IFID_PC4, 32'hC);

        // Branch during PC stall, misaligned target forced aligned.
        t_pcw = 0; t_br = 1; t_bt = 32'h41; tick();
        chk("br_pc", PC_out, 32'h40);
        chk("br_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("br_instr", IFID_Instr, NOP_INSTR);
        // Jump beats branch.
        idle(); t_br = 1; t_bt = 32'h100; t_jp = 1; t_jt = 32'h80; tick();
        chk("jp_pc", PC_out, 32'h80);
        idle(); tick();
        chk("jp_pc4", IFID_PC4, 32'h84);

        // Three-cycle miss, then redirect during a miss.
        t_rdy = 0; tick(); tick(); tick();
        chk("miss_pc", PC_out, 32'h84);
        chk("miss_valid", {31'd0, IFID_Valid}, 32'd0);
        t_br = 1; t_bt = 32'h200; tick();
        chk("miss_redir_pc", PC_out, 32'h200);
        idle(); tick();
        chk("miss_redir_pc4", IFID_PC4, 32'h204);
        chk("miss_redir_instr", IFID_Instr, word(32'h200));

        // PC wrap.
        t_jp = 1; t_jt = 32'hFFFF_FFFC; tick();
        idle(); tick();
        chk("wrap_pc", PC_out, 32'h0);
        chk("wrap_pc4", IFID_PC4, 32'h0);
        chk("wrap_valid", {31'd0, IFID_Valid}, 32'd1);

        // Reset in the middle of a miss.
        t_rdy = 0; tick(); tick();
        t_rst = 1; tick();
        chk("rstmiss_pc", PC_out, RESET_PC);
        chk("rstmiss_valid", {31'd0, IFID_Valid}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            t_rst = ($urandom_range(0, 99) == 0);
            t_pcw = ($urandom_range(0, 99) < 80);
            t_ifw = ($urandom_range(0, 99) < 85);
            t_br  = ($urandom_range(0, 99) < 6);
            t_jp  = ($urandom_range(0, 99) < 3);
            t_rdy = ($urandom_range(0, 99) < 70);
            t_bt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
            t_jt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
